// File: rtl/bicubic_window_buffer_pkg.sv
// Shared constants for the bicubic window buffer slice.
package bicubic_window_buffer_pkg;

  // Default bits per pixel channel
  localparam int DEFAULT_CHANNEL_WIDTH = 8;

  // Side length of the square neighbourhood handed to the upsampler
  localparam int WIN_DIM = 4;

endpackage

// File: rtl/bicubic_window_buffer_if.sv
// Pixel-in / window-out handshake bundle between the feeder and its neighbours.
interface bicubic_window_buffer_if
  import bicubic_window_buffer_pkg::*;
#(
  parameter int CHANNEL_WIDTH = DEFAULT_CHANNEL_WIDTH
) ();

  logic                     src_valid;
  logic                     bf_src_ready;
  logic [CHANNEL_WIDTH-1:0] src_data;

  logic                     bf_req_valid;
  logic                     bcci_req_ready;
  logic [CHANNEL_WIDTH-1:0] p1, p2, p3, p4;
  logic [CHANNEL_WIDTH-1:0] p5, p6, p7, p8;
  logic [CHANNEL_WIDTH-1:0] p9, p10, p11, p12;
  logic [CHANNEL_WIDTH-1:0] p13, p14, p15, p16;

  logic                     bf_frame_done;

  // Environment side: pixel source and window consumer
  modport master (
    output src_valid, src_data, bcci_req_ready,
    input  bf_src_ready, bf_req_valid, bf_frame_done,
    input  p1, p2, p3, p4, p5, p6, p7, p8,
    input  p9, p10, p11, p12, p13, p14, p15, p16
  );

  // Window buffer side
  modport slave (
    input  src_valid, src_data, bcci_req_ready,
    output bf_src_ready, bf_req_valid, bf_frame_done,
    output p1, p2, p3, p4, p5, p6, p7, p8,
    output p9, p10, p11, p12, p13, p14, p15, p16
  );

endinterface

// File: rtl/bicubic_line_buffer.sv
// One image line: synchronous write, combinational read at the same address.
// Kept as its own module so it can be swapped for an SRAM macro later.
module bicubic_line_buffer #(
  parameter int DEPTH  = 960,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wr_data,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Read returns the pre-write contents, which the caller forwards to the next line
  assign rd_data = mem[addr];

  // Store the incoming pixel for this column; no reset, stale data is never observed
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/bicubic_window_buffer.sv
// Raster pixel stream in, 4x4 neighbourhoods out for bicubic_upsample_4.
// Three chained lines hold the rows above the current one; a 4x4 shift
// register collects columns, and a window is offered once it is fully
// populated with pixels from the current row position.
module bicubic_window_buffer
  import bicubic_window_buffer_pkg::*;
#(
  parameter int CHANNEL_WIDTH = DEFAULT_CHANNEL_WIDTH,
  parameter int IMG_W         = 960,
  parameter int IMG_H         = 540,
  parameter int COL_W         = $clog2(IMG_W),
  parameter int ROW_W         = $clog2(IMG_H)
) (
  input logic                   clk,
  input logic                   rst_n,
  bicubic_window_buffer_if.slave bus
);

  logic [COL_W-1:0]         col;
  logic [ROW_W-1:0]         row;
  logic                     req_valid;
  logic                     frame_done;
  logic                     src_ready;
  logic                     src_acc;
  logic                     col_last;
  logic                     row_last;
  logic                     win_hit;

  logic [CHANNEL_WIDTH-1:0] lb0_rd;
  logic [CHANNEL_WIDTH-1:0] lb1_rd;
  logic [CHANNEL_WIDTH-1:0] lb2_rd;
  logic [CHANNEL_WIDTH-1:0] new_col [WIN_DIM];

  // win_q[column][row]: column 0 is leftmost, row 0 is the oldest line
  logic [CHANNEL_WIDTH-1:0] win_q [WIN_DIM][WIN_DIM];

  // Input is taken whenever no window is waiting or the waiting one leaves this cycle
  assign src_ready = ~req_valid | bus.bcci_req_ready;
  assign src_acc   = bus.src_valid & src_ready;
  assign col_last  = (col == COL_W'(IMG_W - 1));
  assign row_last  = (row == ROW_W'(IMG_H - 1));
  assign win_hit   = src_acc
                   & (row >= ROW_W'(WIN_DIM - 1))
                   & (col >= COL_W'(WIN_DIM - 1));

  // Line storage chained newest to oldest: lb2 takes the pixel, lb1 takes lb2, lb0 takes lb1
  bicubic_line_buffer #(
    .DEPTH (IMG_W),
    .WIDTH (CHANNEL_WIDTH),
    .ADDR_W(COL_W)
  ) u_lb2 (
    .clk    (clk),
    .wr_en  (src_acc),
    .addr   (col),
    .wr_data(bus.src_data),
    .rd_data(lb2_rd)
  );

  bicubic_line_buffer #(
    .DEPTH (IMG_W),
    .WIDTH (CHANNEL_WIDTH),
    .ADDR_W(COL_W)
  ) u_lb1 (
    .clk    (clk),
    .wr_en  (src_acc),
    .addr   (col),
    .wr_data(lb2_rd),
    .rd_data(lb1_rd)
  );

  bicubic_line_buffer #(
    .DEPTH (IMG_W),
    .WIDTH (CHANNEL_WIDTH),
    .ADDR_W(COL_W)
  ) u_lb0 (
    .clk    (clk),
    .wr_en  (src_acc),
    .addr   (col),
    .wr_data(lb1_rd),
    .rd_data(lb0_rd)
  );

  // New rightmost column, top to bottom, built from pre-update line contents
  assign new_col[0] = lb0_rd;
  assign new_col[1] = lb1_rd;
  assign new_col[2] = lb2_rd;
  assign new_col[3] = bus.src_data;

  // Raster position of the next pixel to be accepted
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (src_acc) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  // Window handshake: a new complete window wins over the downstream take
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_valid <= 1'b0;
    end else if (win_hit) begin
      req_valid <= 1'b1;
    end else if (req_valid && bus.bcci_req_ready) begin
      req_valid <= 1'b0;
    end
  end

  // One-cycle pulse after the final pixel of the frame is taken
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= src_acc & row_last & col_last;
    end
  end

  // Shift the window left one column per accepted pixel and load the new column
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < WIN_DIM; c++) begin
        for (int r = 0; r < WIN_DIM; r++) begin
          win_q[c][r] <= '0;
        end
      end
    end else if (src_acc) begin
      for (int c = 0; c < WIN_DIM - 1; c++) begin
        for (int r = 0; r < WIN_DIM; r++) begin
          win_q[c][r] <= win_q[c+1][r];
        end
      end
      for (int r = 0; r < WIN_DIM; r++) begin
        win_q[WIN_DIM-1][r] <= new_col[r];
      end
    end
  end

  assign bus.bf_src_ready  = src_ready;
  assign bus.bf_req_valid  = req_valid;
  assign bus.bf_frame_done = frame_done;

  assign bus.p1  = win_q[0][0];
  assign bus.p2  = win_q[0][1];
  assign bus.p3  = win_q[0][2];
  assign bus.p4  = win_q[0][3];
  assign bus.p5  = win_q[1][0];
  assign bus.p6  = win_q[1][1];
  assign bus.p7  = win_q[1][2];
  assign bus.p8  = win_q[1][3];
  assign bus.p9  = win_q[2][0];
  assign bus.p10 = win_q[2][1];
  assign bus.p11 = win_q[2][2];
  assign bus.p12 = win_q[2][3];
  assign bus.p13 = win_q[3][0];
  assign bus.p14 = win_q[3][1];
  assign bus.p15 = win_q[3][2];
  assign bus.p16 = win_q[3][3];

endmodule

// File: tb/tb_bicubic_window_buffer.sv
// Scoreboard bench for bicubic_window_buffer on an 8x6 image, pixel = row*16+col.
module tb_bicubic_window_buffer;

  localparam int IMG_W = 8;
  localparam int IMG_H = 6;

  logic clk = 1'b0;
  logic rst_n;
  int   cycle = 0;
  int   mode = 0;
  int   checks = 0;
  int   passed = 0;
  int   windows_seen = 0;
  int   done_seen = 0;

  logic [127:0] win_q [$];
  int           done_q [$];

  bicubic_window_buffer_if #(.CHANNEL_WIDTH(8)) bus ();

  bicubic_window_buffer #(
    .CHANNEL_WIDTH(8),
    .IMG_W        (IMG_W),
    .IMG_H        (IMG_H)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic [127:0] actual_window();
    return {bus.p1, bus.p2, bus.p3, bus.p4, bus.p5, bus.p6, bus.p7, bus.p8,
            bus.p9, bus.p10, bus.p11, bus.p12, bus.p13, bus.p14, bus.p15, bus.p16};
  endfunction

  // Window whose bottom-right pixel is (r,c); p1 in the top byte
  function automatic logic [127:0] exp_window(int r, int c);
    logic [127:0] v;
    v = '0;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 4; j++) begin
        v[127 - 8*(k*4 + j) -: 8] = 8'((r - 3 + j) * 16 + (c - 3 + k));
      end
    end
    return v;
  endfunction

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic record_fail(string name);
    checks++;
    $display("[TB] FAIL %s: bound expired", name);
  endtask

  // Present one pixel and hold it until it is taken; push expectations on accept
  task automatic send_pixel(int r, int c);
    int waited;
    waited = 0;
    @(negedge clk);
    #1;
    bus.src_valid = 1'b1;
    bus.src_data  = 8'(r * 16 + c);
    while (!bus.bf_src_ready && waited < 64) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!bus.bf_src_ready) begin
      record_fail("accept_timeout");
      bus.src_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (r >= 3 && c >= 3) win_q.push_back(exp_window(r, c));
    if (r == IMG_H - 1 && c == IMG_W - 1) done_q.push_back(cycle + 1);
  endtask

  task automatic applyStimulus(int npix);
    for (int i = 0; i < npix; i++) begin
      send_pixel(i / IMG_W, i % IMG_W);
    end
    @(negedge clk);
    #1;
    bus.src_valid = 1'b0;
  endtask

  // Let the last window drain, then compare per-frame totals
  task automatic checkOutput(string name, int win_before, int done_before,
                             int exp_wins, int exp_dones);
    int i;
    i = 0;
    while ((win_q.size() != 0 || bus.bf_req_valid) && i < 200) begin
      @(negedge clk);
      i++;
    end
    repeat (2) @(negedge clk);
    if (win_q.size() != 0 || bus.bf_req_valid) record_fail({name, "_drain"});
    check({name, "_window_count"}, 128'(windows_seen - win_before), 128'(exp_wins));
    check({name, "_done_count"}, 128'(done_seen - done_before), 128'(exp_dones));
    check({name, "_done_pending"}, 128'(done_q.size()), 128'(0));
  endtask

  task automatic check_reset_state(string name);
    check({name, "_req_valid"}, 128'(bus.bf_req_valid), 128'(0));
    check({name, "_window"}, actual_window(), 128'(0));
    check({name, "_frame_done"}, 128'(bus.bf_frame_done), 128'(0));
    check({name, "_src_ready"}, 128'(bus.bf_src_ready), 128'(1));
  endtask

  // Downstream ready pattern: always ready, or one cycle in four
  initial begin
    bus.bcci_req_ready = 1'b1;
    forever begin
      @(negedge clk);
      bus.bcci_req_ready = (mode == 0) ? 1'b1 : ((cycle % 4) == 0);
    end
  end

  // Monitor: pop and compare on every window handshake and frame-done pulse
  initial begin
    logic [127:0] exp;
    int           exp_cyc;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        if (bus.bf_req_valid && !bus.bcci_req_ready) begin
          check("stall_blocks_input", 128'(bus.bf_src_ready), 128'(0));
        end
        if (bus.bf_req_valid && bus.bcci_req_ready) begin
          windows_seen++;
          if (win_q.size() == 0) begin
            record_fail("unexpected_window");
          end else begin
            exp = win_q.pop_front();
            check("window", actual_window(), exp);
          end
        end
        if (bus.bf_frame_done) begin
          done_seen++;
          if (done_q.size() == 0) begin
            record_fail("unexpected_frame_done");
          end else begin
            exp_cyc = done_q.pop_front();
            check("frame_done_cycle", 128'(cycle), 128'(exp_cyc));
          end
        end
      end
    end
  end

  initial begin
    int wb;
    int db;
    rst_n         = 1'b0;
    bus.src_valid = 1'b1;
    bus.src_data  = 8'hAA;

    // Reset with valid input: nothing counted, outputs cleared
    repeat (3) @(negedge clk);
    #3;
    check_reset_state("reset");
    rst_n         = 1'b1;
    bus.src_valid = 1'b0;

    // Full frame, downstream always ready
    $display("[TB] full frame, ready every cycle");
    mode = 0;
    wb = windows_seen;
    db = done_seen;
    applyStimulus(IMG_W * IMG_H);
    checkOutput("frame_ready", wb, db, 15, 1);

    // Full frame, downstream ready one cycle in four
    $display("[TB] full frame, upsampler-like back-pressure");
    mode = 1;
    wb = windows_seen;
    db = done_seen;
    applyStimulus(IMG_W * IMG_H);
    checkOutput("frame_bp", wb, db, 15, 1);

    // Partial frame, reset, then a clean frame from row 0 column 0
    $display("[TB] reset mid-frame");
    mode = 0;
    wb = windows_seen;
    db = done_seen;
    applyStimulus(20);
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #3;
    check_reset_state("mid_reset");
    check("partial_no_windows", 128'(windows_seen - wb), 128'(0));
    rst_n = 1'b1;
    wb = windows_seen;
    db = done_seen;
    applyStimulus(IMG_W * IMG_H);
    checkOutput("frame_after_reset", wb, db, 15, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/bicubic_window_buffer.md
# bicubic_window_buffer

Upstream feeder for `bicubic_upsample_4`. It accepts one 8-bit channel of a low-resolution image as a raster-order pixel stream. It keeps the last three image rows in line storage and presents every fully-populated 4x4 neighbourhood as sixteen pixels `p1..p16` on the `bf_req_valid`/`bcci_req_ready` handshake. It absorbs the 4-cycle-per-window back-pressure of the upsampler by stalling the input stream.

## Interface
Parameters:
- `CHANNEL_WIDTH`, 8: bits per pixel channel.
- `IMG_W`, 960: input image width in pixels; legal range 4 and up.
- `IMG_H`, 540: input image height in pixels; legal range 4 and up.
- `COL_W`, `$clog2(IMG_W)`: column counter width.
- `ROW_W`, `$clog2(IMG_H)`: row counter width.

Ports:
- `clk`, input, 1: single clock. One clock; reset is synchronous and active-low.
- `rst_n`, input, 1: synchronous active-low reset.
- `src_valid`, input, 1: input pixel valid.
- `bf_src_ready`, output, 1: input pixel accepted when high together with `src_valid`.
- `src_data`, input, `CHANNEL_WIDTH`: input pixel, raster order, row 0 column 0 first.
- `bf_req_valid`, output, 1: `p1..p16` hold a complete window.
- `bcci_req_ready`, input, 1: downstream accepts the window.
- `p1..p16`, output, `CHANNEL_WIDTH` each: the window. `p1..p4` are the leftmost column, top to bottom. `p5..p8` are the next column. `p13..p16` are the rightmost column, whose bottom entry is the newest pixel.
- `bf_frame_done`, output, 1: one-cycle pulse when the last pixel of a frame is accepted.

## Operation
- Accept: `src_acc = src_valid & bf_src_ready`, with `bf_src_ready = ~bf_req_valid | bcci_req_ready` (combinational from the downstream ready).
- Counters `col` and `row` track the position of the next pixel to be accepted.
  - On `src_acc`, `col` increments and wraps from `IMG_W-1` to 0.
  - `row` increments on that column wrap, and wraps from `IMG_H-1` to 0, which is the frame end.
- Line storage: three rows `lb0` (oldest), `lb1`, `lb2`, each `IMG_W` entries.
  - On `src_acc` at column c: `lb0[c]<=lb1[c]`, `lb1[c]<=lb2[c]`, `lb2[c]<=src_data`.
- Window register: a 4x4 array.
  - On `src_acc`, shift every column left by one.
  - Load the new rightmost column as {`lb0[c]`, `lb1[c]`, `lb2[c]`, `src_data`}, top to bottom, using pre-update line values.
  - Outputs `p1..p16` are driven directly from this register. It changes only on `src_acc`.
- Window-complete condition: `win = src_acc & (row>=3) & (col>=3)`, evaluated on pre-increment counter values.
- `bf_req_valid` update:
  - Set on `win`.
  - Else clear on `bf_req_valid & bcci_req_ready`.
  - Else hold.
- Pixels in rows 0–2 or columns 0–2 update storage but never raise `bf_req_valid`. Each frame therefore yields (IMG_W-3)*(IMG_H-3) windows.
- At a row start (`col` = 0..2), the window holds stale columns from the previous row. These are never presented because `win` is low there.
- `bf_frame_done` is registered: high the cycle after `src_acc` with `row==IMG_H-1` and `col==IMG_W-1`.
- No edge padding. Border handling, if ever needed, belongs to a separate block.

## Timing
- Reset (`rst_n` low at a clock edge) sets `col=0`, `row=0`, `bf_req_valid=0`, `bf_frame_done=0`, and all window registers (so `p1..p16`) to 0.
- Line storage is not reset. Its contents are never observable before being overwritten, because of the `win` gating.
- `bf_src_ready` is 1 during and after reset while `bf_req_valid=0`.
- Latency: the window is visible, with `bf_req_valid=1`, on the cycle after the accept of its bottom-right pixel.
- Throughput: one pixel per cycle while downstream is ready every cycle. With `bcci_req_ready` high once every 4 cycles (the upsampler in steady state), one window is issued per 4 cycles.
- Simultaneous downstream handshake and new `src_acc` completing a window: `bf_req_valid` stays 1 and `p1..p16` switch to the new window next cycle. No bubble, no duplicate.
- Stall: while `bf_req_valid=1 & bcci_req_ready=0`, `bf_src_ready=0` and `p1..p16`, counters and storage hold.
- Reset mid-frame discards the partial frame. The next accepted pixel is treated as row 0, column 0.

## Structure
- `CHANNEL_WIDTH` and the window dimension constant (4) belong in the shared `define.v`.
- State registers use the existing `dfflr`.
- One natural sub-module: `bicubic_line_buffer`, a single `IMG_W`x`CHANNEL_WIDTH` line with one synchronous write port and one combinational read port at the same address.
  - Instantiate it three times, chained `lb2`→`lb1`→`lb0`.
  - This allows a later swap to SRAM macros.
- Top-level RTL: roughly 200–300 lines.

## Test plan
Use `IMG_W=8`, `IMG_H=6`, and pixel value = `row*16+col`.
- **Reset:** hold `rst_n`=0 for 3 cycles with `src_valid`=1 → `bf_req_valid`=0, `p1..p16`=0, `bf_frame_done`=0, `bf_src_ready`=1; no pixel is counted.
- **First window:** stream with `bcci_req_ready`=1 constantly → first `bf_req_valid` appears the cycle after pixel 0x33 is accepted, with `p1..p4`=00,10,20,30 and `p13..p16`=03,13,23,33.
- **Full frame:** same stream → exactly 15 windows. The last window has `p16`=0x57, `p1`=0x24. `bf_frame_done` pulses once, the cycle after 0x57 is accepted.
- **Upsampler-like back-pressure:** `bcci_req_ready` high 1 cycle in 4 → 15 windows in order, each held stable while stalled, and no input accepted while a window is pending.
- **Simultaneous accept:** window 0x33 pending and `bcci_req_ready`=1 with pixel 0x34 presented → next cycle `bf_req_valid`=1, `p16`=0x34, `p13`=0x04.
- **Reset mid-frame:** assert reset after 20 pixels, then restart the stream → behaviour identical to the first-window case.
